axis_flit_queue: RTL and testbench



---
 rtl/axis_flit_queue_pkg.sv | 19 +
 rtl/flit_ram.sv | 18 +
 rtl/axis_flit_queue.sv | 70 +++++++
 tb/tb_axis_flit_queue.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/axis_flit_queue_pkg.sv
// axis_flit_queue_pkg: AXIS flit types and the PMU counter helper shared by the flit queue.
package axis_flit_queue_pkg;
   localparam int AXIS_DATA_W = 32;
   localparam int PMU_CNT_W = 32;
   typedef struct packed {
      logic tvalid;
      logic [AXIS_DATA_W-1:0] tdata;
      logic tlast;
   } axis_mosi_t;
   typedef struct packed {
      logic tready;
   } axis_miso_t;
   // Increment that sticks at all-ones for a counter w bits wide (w <= 64).
   function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
      logic [63:0] top;
      top = (w >= 64) ? '1 : (64'(1) << w) - 64'(1);
      return (v == top) ? v : v + 64'(1);
   endfunction
endpackage

// File: rtl/flit_ram.sv
// flit_ram: DEPTH x W storage with one synchronous write port and one asynchronous read port.
module flit_ram #(
   parameter int DEPTH = 8,
   parameter int W = 34
) (
   input  logic clk_i,
   input  logic we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [W-1:0] wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [W-1:0] rdata_o
);
   logic [W-1:0] mem [DEPTH];
   always_ff @(posedge clk_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
   end
   assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/axis_flit_queue.sv
// axis_flit_queue: per-port AXIS flit buffer with optional store-and-forward by packet and PMU counters.
module axis_flit_queue
   import axis_flit_queue_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int PACKET_MODE = 1,
   parameter int CNT_W = PMU_CNT_W
) (
   input  logic clk_i,
   input  logic rst_i,
   input  axis_mosi_t in_mosi_i,
   output axis_miso_t in_miso_o,
   output axis_mosi_t out_mosi_o,
   input  axis_miso_t out_miso_i,
   output logic [$clog2(DEPTH):0] occupancy_o,
   output logic [$clog2(DEPTH):0] pkt_count_o,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic [CNT_W-1:0] flit_count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] occ, pkt;
   logic in_pkt, in_ready, out_valid, push, pop;
   logic [CNT_W-1:0] stall_q, flit_q;
   axis_mosi_t rd_flit;
   flit_ram #(.DEPTH(DEPTH), .W($bits(axis_mosi_t))) u_ram (
      .clk_i(clk_i),
      .we_i(push),
      .waddr_i(wr_ptr),
      .wdata_i(in_mosi_i),
      .raddr_i(rd_ptr),
      .rdata_o(rd_flit)
   );
   // A full queue is released even without TLAST so over-long packets cannot deadlock.
   always_comb begin
      in_ready = occ != FULL;
      out_valid = (PACKET_MODE != 0) ? (pkt != '0 || occ == FULL || (in_pkt && occ != '0)) : occ != '0;
      push = in_mosi_i.tvalid & in_ready;
      pop = out_valid & out_miso_i.tready;
      in_miso_o = '{tready: in_ready};
      out_mosi_o = rd_flit;
      out_mosi_o.tvalid = out_valid;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ <= '0;
         pkt <= '0;
         in_pkt <= 1'b0;
         stall_q <= '0;
         flit_q <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            in_pkt <= ~rd_flit.tlast;
            flit_q <= flit_q + CNT_W'(1);
         end
         occ <= occ + (AW+1)'(push) - (AW+1)'(pop);
         pkt <= pkt + (AW+1)'(push & in_mosi_i.tlast) - (AW+1)'(pop & rd_flit.tlast);
         if (in_mosi_i.tvalid & ~in_ready) stall_q <= CNT_W'(sat_inc(64'(stall_q), CNT_W));
      end
   end
   assign occupancy_o = occ;
   assign pkt_count_o = pkt;
   assign stall_cycles_o = stall_q;
   assign flit_count_o = flit_q;
endmodule

// File: tb/tb_axis_flit_queue.sv
// tb_axis_flit_queue: FIFO-mode and packet-mode queues against a queue-based reference model and scoreboard.
module tb_axis_flit_queue;
   import axis_flit_queue_pkg::*;
   typedef struct packed {
      logic [AXIS_DATA_W-1:0] d;
      logic l;
   } fl_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   axis_mosi_t imosi[2], omosi[2];
   axis_miso_t imiso[2], omiso[2];
   logic [3:0] occ[2], pktc[2];
   logic [31:0] stall[2], flits[2];
   bit rnd[2];
   int vec = 0, errs = 0;
   always #5 clk = ~clk;
   task automatic chk(input string n, input int m, input logic [63:0] a, input logic [63:0] e);
      vec++;
      if (a !== e) begin
         errs++;
         $display("FAIL %s[%0d]: got %0h expected %0h at %0t", n, m, a, e, $time);
      end
   endtask
   function automatic int nlast(input fl_t qq[$]);
      int c = 0;
      foreach (qq[i]) c += int'(qq[i].l);
      return c;
   endfunction
   // Reference valid rule: FIFO shows any stored flit; packet mode needs a whole packet,
   // a full queue, or an already-started packet still draining.
   function automatic bit mvalid(input fl_t qq[$], input bit started, input int pm);
      return pm != 0 ? (nlast(qq) > 0 || qq.size() == 8 || (started && qq.size() > 0)) : qq.size() > 0;
   endfunction
   for (genvar g = 0; g < 2; g++) begin : gen_q
      fl_t q[$], sb[$];
      bit mpkt = 1'b0;
      int mstall = 0, mflits = 0;
      axis_flit_queue #(.DEPTH(8), .PACKET_MODE(g), .CNT_W(32)) dut (
         .clk_i(clk),
         .rst_i(rst),
         .in_mosi_i(imosi[g]),
         .in_miso_o(imiso[g]),
         .out_mosi_o(omosi[g]),
         .out_miso_i(omiso[g]),
         .occupancy_o(occ[g]),
         .pkt_count_o(pktc[g]),
         .stall_cycles_o(stall[g]),
         .flit_count_o(flits[g])
      );
      initial forever begin
         fl_t f;
         @(negedge clk);
         chk("in_ready", g, 64'(imiso[g].tready), 64'(q.size() != 8));
         chk("out_valid", g, 64'(omosi[g].tvalid), 64'(mvalid(q, mpkt, g)));
         chk("occupancy", g, 64'(occ[g]), 64'(q.size()));
         chk("pkt_count", g, 64'(pktc[g]), 64'(nlast(q)));
         chk("stall_cycles", g, 64'(stall[g]), 64'(mstall));
         chk("flit_count", g, 64'(flits[g]), 64'(mflits));
         if (omosi[g].tvalid === 1'b1 && omiso[g].tready) begin
            if (sb.size() == 0) begin
               vec++;
               errs++;
               $display("FAIL pop_unexpected[%0d]: got data %0h, required no flit at %0t", g, omosi[g].tdata, $time);
            end else begin
               f = sb.pop_front();
               chk("data", g, 64'(omosi[g].tdata), 64'(f.d));
               chk("tlast", g, 64'(omosi[g].tlast), 64'(f.l));
            end
         end
      end
      initial forever begin
         fl_t f;
         bit rdy, vld;
         @(posedge clk);
         if (rst) begin
            q.delete();
            sb.delete();
            mpkt = 1'b0;
            mstall = 0;
            mflits = 0;
         end else begin
            rdy = q.size() != 8;
            vld = mvalid(q, mpkt, g);
            if (imosi[g].tvalid && !rdy) mstall++;
            if (vld && omiso[g].tready) begin
               f = q.pop_front();
               mpkt = !f.l;
               mflits++;
            end
            if (imosi[g].tvalid && rdy) begin
               f = '{d: imosi[g].tdata, l: imosi[g].tlast};
               q.push_back(f);
               sb.push_back(f);
            end
         end
      end
   end
   task automatic send(input int m, input logic [31:0] d, input logic l);
      bit ok = 1'b0;
      imosi[m] = '{tvalid: 1'b1, tdata: d, tlast: l};
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk);
         ok = imiso[m].tready;
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         vec++;
         errs++;
         $display("FAIL send_timeout[%0d]: got in_ready 0 for 200 cycles, required 1", m);
         imosi[m].tvalid = 1'b0;
      end
   endtask
   task automatic idle(input int m, input int k);
      imosi[m].tvalid = 1'b0;
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic drain(input int m);
      bit e = 1'b0;
      for (int t = 0; t < 300 && !e; t++) begin
         @(negedge clk);
         e = occ[m] == 4'd0;
      end
      if (!e) begin
         vec++;
         errs++;
         $display("FAIL drain_timeout[%0d]: got occupancy %0d, required 0", m, occ[m]);
      end
      @(posedge clk);
      #1;
   endtask
   task automatic rand_traffic(input int m, input int n, input int maxlen);
      int len;
      rnd[m] = 1'b1;
      repeat (n) begin
         len = $urandom_range(1, maxlen);
         for (int i = 0; i < len; i++) send(m, $urandom, i == len - 1);
         if ($urandom_range(0, 2) == 0) idle(m, $urandom_range(1, 3));
      end
      idle(m, 0);
      rnd[m] = 1'b0;
      #2;
      omiso[m].tready = 1'b1;
      drain(m);
   endtask
   initial forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) if (rnd[i]) omiso[i].tready = 1'($urandom_range(0, 1));
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish within 50000 cycles");
      $fatal(1, "watchdog");
   end
   initial begin
      for (int i = 0; i < 2; i++) begin
         imosi[i] = '0;
         omiso[i].tready = 1'b0;
         rnd[i] = 1'b0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      omiso[0].tready = 1'b1;
      for (int i = 0; i < 3; i++) send(0, 32'h10 + 32'(i), i == 2);
      idle(0, 4);
      chk("m0_three_flits", 0, 64'(flits[0]), 64'd3);
      omiso[1].tready = 1'b1;
      for (int i = 0; i < 4; i++) send(1, 32'h40 + 32'(i), i == 3);
      idle(1, 6);
      chk("m1_four_flits", 1, 64'(flits[1]), 64'd4);
      chk("m1_pkt_zero", 1, 64'(pktc[1]), 64'd0);
      omiso[0].tready = 1'b0;
      for (int i = 0; i < 8; i++) send(0, 32'h100 + 32'(i), 1'b1);
      imosi[0] = '{tvalid: 1'b1, tdata: 32'h108, tlast: 1'b1};
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      chk("fill_stall", 0, 64'(stall[0]), 64'd2);
      chk("fill_occ", 0, 64'(occ[0]), 64'd8);
      chk("fill_ready", 0, 64'(imiso[0].tready), 64'd0);
      omiso[0].tready = 1'b1;
      send(0, 32'h108, 1'b1);
      send(0, 32'h109, 1'b1);
      idle(0, 0);
      drain(0);
      for (int i = 0; i < 12; i++) send(1, 32'h200 + 32'(i), i == 11);
      idle(1, 0);
      drain(1);
      chk("escape_flits", 1, 64'(flits[1]), 64'd16);
      rand_traffic(1, 20, 1);
      fork
         rand_traffic(0, 40, 6);
         rand_traffic(1, 40, 6);
      join
      omiso[1].tready = 1'b0;
      for (int i = 0; i < 5; i++) send(1, 32'h500 + 32'(i), 1'b0);
      idle(1, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_occ", 1, 64'(occ[1]), 64'd0);
      chk("rst_valid", 1, 64'(omosi[1].tvalid), 64'd0);
      chk("rst_pkt", 1, 64'(pktc[1]), 64'd0);
      chk("rst_flits", 1, 64'(flits[1]), 64'd0);
      chk("rst_stall", 0, 64'(stall[0]), 64'd0);
      omiso[1].tready = 1'b1;
      for (int i = 0; i < 3; i++) send(1, 32'h600 + 32'(i), i == 2);
      idle(1, 0);
      drain(1);
      chk("post_rst_flits", 1, 64'(flits[1]), 64'd3);
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
